// File: rtl/sinc_interp_seq.sv
// rtl/sinc_interp_seq.sv - upstream sequencer for the 19-tap polyphase sinc interpolator
//
// Buffers one input sample (valid/ready), then sequences the filter: one
// ADVANCE cycle (pre_load/sinc_en high, sample shifted in) followed by INTERP
// phase selections. A FILTER_LATENCY-deep tag pipe marks which filter outputs
// are real interpolated samples.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_sample/in_valid/in_ready   16-bit signed sample handshake
//   phase_en          output-rate enable, phase counter advances only when high
//   filt_sample, pre_load, sinc_en, sinc_select   filter controls
//   out_valid, out_phase          tag aligned with the filter's registered output
//   busy              state is not IDLE
//   underrun          sticky: a phase sweep ended with no sample buffered
module sinc_interp_seq #(
  parameter int INTERP         = 10,
  parameter int PHASE_START    = 1,
  parameter int FILTER_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_sample,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        phase_en,
  output logic [15:0] filt_sample,
  output logic        pre_load,
  output logic        sinc_en,
  output logic [4:0]  sinc_select,
  output logic        out_valid,
  output logic [4:0]  out_phase,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    PHASE   = 2'd2
  } state_t;

  localparam logic [4:0] LAST_CNT  = 5'(INTERP - 1);
  localparam logic [4:0] START_SEL = 5'(PHASE_START);

  state_t state, state_nxt;

  logic [15:0] hold;
  logic        hold_valid;
  logic [4:0]  cnt;
  logic        accept;
  logic        sweep_end;

  logic [FILTER_LATENCY-1:0]      tag_valid;
  logic [FILTER_LATENCY-1:0][4:0] tag_phase;

  assign in_ready    = !hold_valid;
  assign accept      = in_valid && in_ready;
  assign filt_sample = hold;
  assign busy        = (state != IDLE);
  assign out_valid   = tag_valid[FILTER_LATENCY-1];
  assign out_phase   = tag_phase[FILTER_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pre_load    = 1'b0;
    sinc_en     = 1'b0;
    sinc_select = 5'd0;
    sweep_end   = 1'b0;
    case (state)
      IDLE: begin
        if (hold_valid) state_nxt = ADVANCE;
      end
      ADVANCE: begin
        pre_load  = 1'b1;
        sinc_en   = 1'b1;
        state_nxt = PHASE;
      end
      PHASE: begin
        sinc_select = START_SEL + cnt;
        if (phase_en && cnt == LAST_CNT) begin
          sweep_end = 1'b1;
          // A sample accepted on this very cycle is enough to keep streaming.
          state_nxt = (hold_valid || accept) ? ADVANCE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= 16'd0;
      hold_valid <= 1'b0;
      cnt        <= 5'd0;
      underrun   <= 1'b0;
      tag_valid  <= '0;
      tag_phase  <= '0;
    end else begin
      if (accept) begin
        hold       <= in_sample;
        hold_valid <= 1'b1;
      end else if (state == ADVANCE) begin
        hold_valid <= 1'b0;
      end

      if (state == ADVANCE)
        cnt <= 5'd0;
      else if (state == PHASE && phase_en && cnt < LAST_CNT)
        cnt <= cnt + 5'd1;

      if (sweep_end && !(hold_valid || accept))
        underrun <= 1'b1;

      // Only enabled phase cycles produce a real filter output later on.
      tag_valid[0] <= (state == PHASE) && phase_en;
      tag_phase[0] <= ((state == PHASE) && phase_en) ? sinc_select : 5'd0;
      for (int i = 1; i < FILTER_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_phase[i] <= tag_phase[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sinc_interp_seq.sv
// tb/tb_sinc_interp_seq.sv - self-checking bench for sinc_interp_seq
module tb_sinc_interp_seq;
  localparam int INTERP      = 10;
  localparam int PHASE_START = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_sample = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        phase_en;
  logic [15:0] filt_sample;
  logic        pre_load, sinc_en, out_valid, busy, underrun;
  logic [4:0]  sinc_select, out_phase;

  sinc_interp_seq #(.INTERP(10), .PHASE_START(1), .FILTER_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(in_ready), .phase_en(phase_en), .filt_sample(filt_sample),
    .pre_load(pre_load), .sinc_en(sinc_en), .sinc_select(sinc_select),
    .out_valid(out_valid), .out_phase(out_phase), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_pre, n_ov, n_busy, n_und_early;
  int pmode = 0;

  logic [15:0] samp_q[$];
  logic [4:0]  phase_q[$];

  typedef struct {
    logic [15:0] base;
    int          count;
    int          alt;
    int          exp_pre;
    int          exp_ov;
    int          exp_busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    pmode = 0;
    repeat (3) tick();
    rst = 1'b0;
    n_pre = 0; n_ov = 0; n_busy = 0; n_und_early = 0;
  endtask

  task automatic present(input logic [15:0] v, output int stalls);
    stalls = 0;
    in_sample = v;
    in_valid = 1'b1;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (stalls >= 200) check("accept_timeout", 1, 0);
  endtask

  task automatic drain();
    int done;
    done = 0;
    for (int w = 0; w < 400; w++) begin
      @(negedge clk);
      if (!busy && samp_q.size() == 0 && phase_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    check("drain_done", done, 1);
    tick();
  endtask

  // phase_en: tied high (mode 0) or toggling every cycle (mode 1)
  initial begin
    phase_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pmode == 1) phase_en = ~phase_en;
      else            phase_en = 1'b1;
    end
  end

  // Scoreboard: accepts push the sample and its phase sequence; pre_load and
  // out_valid pop and compare.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        samp_q.delete();
        phase_q.delete();
      end else begin
        if (in_valid && in_ready) begin
          samp_q.push_back(in_sample);
          for (int k = 0; k < INTERP; k++) phase_q.push_back(5'(PHASE_START + k));
        end
        if (pre_load) begin
          n_pre++;
          check("sinc_en_with_pre_load", sinc_en, 1);
          if (samp_q.size() == 0) check("pre_load_without_sample", 1, 0);
          else check("filt_sample", filt_sample, samp_q.pop_front());
        end
        if (out_valid) begin
          n_ov++;
          if (phase_q.size() == 0) check("out_valid_spurious", 1, 0);
          else check("out_phase", out_phase, phase_q.pop_front());
        end
        if (busy) n_busy++;
        if (busy && underrun) n_und_early++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   st;
    logic [15:0] a_v;

    vecs[0] = '{16'h0001, 3, 0, 3, 30, 33};
    vecs[1] = '{16'h8000, 1, 0, 1, 10, 11};
    vecs[2] = '{16'h7fff, 2, 1, 2, 20, -1};
    vecs[3] = '{16'hfff0, 4, 0, 4, 40, 44};
    vecs[4] = '{16'h0100, 1, 1, 1, 10, -1};

    // Reset with in_valid asserted: nothing may be accepted.
    rst = 1'b1;
    in_valid = 1'b1;
    in_sample = 16'hdead;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_pre_load", pre_load, 0);
      check("rst_sinc_en", sinc_en, 0);
      check("rst_sinc_select", sinc_select, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_underrun", underrun, 0);
      check("rst_busy", busy, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_in_ready", in_ready, 1);
    end
    tick();

    // Single sample, exact cycle timing (cycle c = state after edge c).
    in_sample = 16'h1234;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      check("t2_pre_load", pre_load, (c == 1) ? 1 : 0);
      check("t2_sinc_select", sinc_select, (c >= 2 && c <= 11) ? c - 1 : 0);
      check("t2_out_valid", out_valid, (c >= 4 && c <= 13) ? 1 : 0);
      check("t2_out_phase", out_phase, (c >= 4 && c <= 13) ? c - 3 : 0);
      check("t2_busy", busy, (c >= 1 && c <= 11) ? 1 : 0);
      check("t2_underrun", underrun, (c >= 12) ? 1 : 0);
      if (c == 1) check("t2_filt_sample", filt_sample, 16'h1234);
    end
    drain();

    // Table-driven streams.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      pmode = vecs[r].alt;
      for (int i = 0; i < vecs[r].count; i++) present(vecs[r].base + 16'(i), st);
      drain();
      check("row_pre_load_count", n_pre, vecs[r].exp_pre);
      check("row_out_valid_count", n_ov, vecs[r].exp_ov);
      if (vecs[r].exp_busy >= 0) check("row_busy_cycles", n_busy, vecs[r].exp_busy);
      check("row_underrun_mid_stream", n_und_early, 0);
      check("row_underrun_end", underrun, 1);
    end

    // Backpressure: B waits only for ADVANCE, C waits for the next ADVANCE.
    do_reset();
    tick();
    present(16'haaaa, st);
    check("bp_a_stalls", st, 0);
    present(16'hbbbb, st);
    check("bp_b_stalls", st, 2);
    present(16'hcccc, st);
    check("bp_c_stalls", st, 10);
    drain();
    check("bp_pre_load_count", n_pre, 3);
    check("bp_out_valid_count", n_ov, 30);
    check("bp_underrun_mid_stream", n_und_early, 0);

    // Reset at the 5th phase with a second sample buffered.
    do_reset();
    tick();
    present(16'h5555, st);
    present(16'h6666, st);
    a_v = 16'd0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (sinc_select == 5'd5) begin
        a_v = 16'd1;
        break;
      end
    end
    check("mid_rst_reached_phase5", a_v, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_underrun", underrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_mid_rst_out_valid", out_valid, 0);
      check("post_mid_rst_busy", busy, 0);
      check("post_mid_rst_underrun", underrun, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
